// File: rtl/uncache_axi_bridge_if.sv
// Bundles the uncache request port and the five AXI4 channels of the bridge.
// The bridge uses the slave view; the requester/AXI environment uses master.
interface uncache_axi_bridge_if;
  // uncache request side
  logic        axi_en;
  logic [3:0]  axi_wsel;
  logic [31:0] axi_addr;
  logic [31:0] axi_wdata;
  logic        reload;
  logic [31:0] axi_rdata;
  logic        resp_err;
  // AR / R
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;
  // AW / W / B
  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  modport slave (
    input  axi_en, axi_wsel, axi_addr, axi_wdata,
    output reload, axi_rdata, resp_err,
    output arid, araddr, arvalid, input arready,
    input  rdata, rresp, rlast, rvalid, output rready,
    output awid, awaddr, awvalid, input awready,
    output wdata, wstrb, wlast, wvalid, input wready,
    input  bresp, bvalid, output bready
  );

  modport master (
    output axi_en, axi_wsel, axi_addr, axi_wdata,
    input  reload, axi_rdata, resp_err,
    input  arid, araddr, arvalid, output arready,
    output rdata, rresp, rlast, rvalid, input rready,
    input  awid, awaddr, awvalid, output awready,
    input  wdata, wstrb, wlast, wvalid, output wready,
    output bresp, bvalid, input bready
  );
endinterface

// File: rtl/uncache_axi_bridge.sv
// Turns one outstanding uncache request into a single-beat AXI4 read or write.
// Every output is a register; completion is a one-cycle reload pulse.
module uncache_axi_bridge #(
  parameter logic [3:0] AXI_ID = 4'b0000
) (
  input logic                clk,
  input logic                resetn,
  uncache_axi_bridge_if.slave bus
);

  typedef enum logic [5:0] {
    S_IDLE = 6'b000001,
    S_AR   = 6'b000010,
    S_R    = 6'b000100,
    S_WR   = 6'b001000,
    S_B    = 6'b010000,
    S_DONE = 6'b100000
  } state_e;

  state_e      state_q, state_d;
  logic        arvalid_q, arvalid_d;
  logic        rready_q,  rready_d;
  logic        awvalid_q, awvalid_d;
  logic        wvalid_q,  wvalid_d;
  logic        wlast_q,   wlast_d;
  logic        bready_q,  bready_d;
  logic        aw_done_q, aw_done_d;
  logic        w_done_q,  w_done_d;
  logic        reload_q,  reload_d;
  logic        err_q,     err_d;
  logic [31:0] araddr_q,  araddr_d;
  logic [31:0] awaddr_q,  awaddr_d;
  logic [31:0] wdata_q,   wdata_d;
  logic [3:0]  wstrb_q,   wstrb_d;
  logic [31:0] rdata_q,   rdata_d;

  logic ar_fire, r_fire, aw_fire, w_fire, b_fire;

  assign ar_fire = arvalid_q & bus.arready;
  assign r_fire  = rready_q  & bus.rvalid;
  assign aw_fire = awvalid_q & bus.awready;
  assign w_fire  = wvalid_q  & bus.wready;
  assign b_fire  = bready_q  & bus.bvalid;

  always_comb begin
    state_d   = state_q;
    arvalid_d = arvalid_q;
    rready_d  = rready_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    wlast_d   = wlast_q;
    bready_d  = bready_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    reload_d  = reload_q;
    err_d     = err_q;
    araddr_d  = araddr_q;
    awaddr_d  = awaddr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    rdata_d   = rdata_q;

    case (state_q)
      S_IDLE: begin
        if (bus.axi_en) begin
          if (bus.axi_wsel == 4'b0000) begin
            araddr_d  = bus.axi_addr;
            arvalid_d = 1'b1;
            state_d   = S_AR;
          end else begin
            awaddr_d  = bus.axi_addr;
            wdata_d   = bus.axi_wdata;
            wstrb_d   = bus.axi_wsel;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            wlast_d   = 1'b1;
            aw_done_d = 1'b0;
            w_done_d  = 1'b0;
            state_d   = S_WR;
          end
        end
      end
      S_AR: begin
        if (ar_fire) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = S_R;
        end
      end
      S_R: begin
        // LEN is 0, so the first beat is the last; rlast is not consulted
        if (r_fire) begin
          rdata_d  = bus.rdata;
          err_d    = bus.rresp[1];
          rready_d = 1'b0;
          reload_d = 1'b1;
          state_d  = S_DONE;
        end
      end
      S_WR: begin
        // each channel retires on its own handshake and is never re-issued
        if (aw_fire) begin
          awvalid_d = 1'b0;
          aw_done_d = 1'b1;
        end
        if (w_fire) begin
          wvalid_d = 1'b0;
          wlast_d  = 1'b0;
          w_done_d = 1'b1;
        end
        if (aw_done_d && w_done_d) begin
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          bready_d  = 1'b1;
          state_d   = S_B;
        end
      end
      S_B: begin
        if (b_fire) begin
          bready_d = 1'b0;
          err_d    = bus.bresp[1];
          reload_d = 1'b1;
          state_d  = S_DONE;
        end
      end
      S_DONE: begin
        reload_d = 1'b0;
        err_d    = 1'b0;
        state_d  = S_IDLE;
      end
      default: begin
        arvalid_d = 1'b0;
        rready_d  = 1'b0;
        awvalid_d = 1'b0;
        wvalid_d  = 1'b0;
        wlast_d   = 1'b0;
        bready_d  = 1'b0;
        reload_d  = 1'b0;
        err_d     = 1'b0;
        state_d   = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= S_IDLE;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      wlast_q   <= 1'b0;
      bready_q  <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      reload_q  <= 1'b0;
      err_q     <= 1'b0;
      araddr_q  <= 32'h0;
      awaddr_q  <= 32'h0;
      wdata_q   <= 32'h0;
      wstrb_q   <= 4'h0;
      rdata_q   <= 32'h0;
    end else begin
      state_q   <= state_d;
      arvalid_q <= arvalid_d;
      rready_q  <= rready_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      wlast_q   <= wlast_d;
      bready_q  <= bready_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      reload_q  <= reload_d;
      err_q     <= err_d;
      araddr_q  <= araddr_d;
      awaddr_q  <= awaddr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      rdata_q   <= rdata_d;
    end
  end

  assign bus.reload    = reload_q;
  assign bus.resp_err  = err_q;
  assign bus.axi_rdata = rdata_q;
  assign bus.arid      = AXI_ID;
  assign bus.araddr    = araddr_q;
  assign bus.arvalid   = arvalid_q;
  assign bus.rready    = rready_q;
  assign bus.awid      = AXI_ID;
  assign bus.awaddr    = awaddr_q;
  assign bus.awvalid   = awvalid_q;
  assign bus.wdata     = wdata_q;
  assign bus.wstrb     = wstrb_q;
  assign bus.wlast     = wlast_q;
  assign bus.wvalid    = wvalid_q;
  assign bus.bready    = bready_q;

endmodule

// File: tb/tb_uncache_axi_bridge.sv
// Directed bench for uncache_axi_bridge: a vector table of requests against a
// wait-state-programmable AXI slave, plus an async-reset-in-flight sequence.
module tb_uncache_axi_bridge;

  logic clk;
  logic resetn;

  uncache_axi_bridge_if u_if();

  uncache_axi_bridge #(.AXI_ID(4'b0000)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (u_if.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wsel;
    int          arw, rw, aww, ww, bw;  // slave wait cycles per channel
    logic [31:0] rdata;
    logic [1:0]  resp;
    int          exp_lat;
    logic        exp_err;
    logic [31:0] exp_rdata;
    int          exp_a_cyc;             // cycles AR (read) or AW (write) valid is high
    int          exp_w_cyc;
  } vec_t;

  vec_t vecs[8];
  vec_t cur;

  int checks = 0;
  int errors = 0;

  int ar_cnt, r_cnt, aw_cnt, w_cnt, b_cnt;
  int ar_hi, aw_hi, w_hi;
  int ar_hs, r_hs, aw_hs, w_hs, b_hs;
  logic [31:0] cap_araddr, cap_awaddr, cap_wdata;
  logic [3:0]  cap_wstrb;
  logic        cap_wlast;

  // AXI slave: each ready/valid rises after its programmed wait, set mid-cycle
  always @(negedge clk) begin
    u_if.rdata = cur.rdata;
    u_if.rresp = cur.resp;
    u_if.bresp = cur.resp;
    u_if.rlast = 1'b1;
    if (u_if.arvalid) begin u_if.arready = (ar_cnt >= cur.arw); ar_cnt++; end
    else begin u_if.arready = 1'b0; ar_cnt = 0; end
    if (u_if.rready) begin u_if.rvalid = (r_cnt >= cur.rw); r_cnt++; end
    else begin u_if.rvalid = 1'b0; r_cnt = 0; end
    if (u_if.awvalid) begin u_if.awready = (aw_cnt >= cur.aww); aw_cnt++; end
    else begin u_if.awready = 1'b0; aw_cnt = 0; end
    if (u_if.wvalid) begin u_if.wready = (w_cnt >= cur.ww); w_cnt++; end
    else begin u_if.wready = 1'b0; w_cnt = 0; end
    if (u_if.bready) begin u_if.bvalid = (b_cnt >= cur.bw); b_cnt++; end
    else begin u_if.bvalid = 1'b0; b_cnt = 0; end
    if (u_if.arvalid) begin ar_hi++; cap_araddr = u_if.araddr; end
    if (u_if.awvalid) begin aw_hi++; cap_awaddr = u_if.awaddr; end
    if (u_if.wvalid) begin
      w_hi++; cap_wdata = u_if.wdata; cap_wstrb = u_if.wstrb; cap_wlast = u_if.wlast;
    end
  end

  always @(posedge clk) begin
    if (u_if.arvalid && u_if.arready) ar_hs++;
    if (u_if.rvalid  && u_if.rready)  r_hs++;
    if (u_if.awvalid && u_if.awready) aw_hs++;
    if (u_if.wvalid  && u_if.wready)  w_hs++;
    if (u_if.bvalid  && u_if.bready)  b_hs++;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, " ctl"}, {24'h0, u_if.reload, u_if.resp_err, u_if.arvalid, u_if.awvalid,
                       u_if.wvalid, u_if.wlast, u_if.rready, u_if.bready}, 32'h0);
    chk({nm, " axi_rdata"}, u_if.axi_rdata, 32'h0);
    chk({nm, " araddr"}, u_if.araddr, 32'h0);
    chk({nm, " awaddr"}, u_if.awaddr, 32'h0);
    chk({nm, " wdata"}, u_if.wdata, 32'h0);
    chk({nm, " wstrb"}, {28'h0, u_if.wstrb}, 32'h0);
  endtask

  // Called #1 after a rising edge; the request is sampled at the next edge.
  task automatic run(input int idx, input vec_t v);
    int lat;
    logic got;
    string p;
    p = $sformatf("v%0d", idx);
    chk({p, " idle before req"}, {30'h0, u_if.arvalid, u_if.awvalid}, 32'h0);
    cur = v;
    ar_hi = 0; aw_hi = 0; w_hi = 0;
    ar_hs = 0; r_hs = 0; aw_hs = 0; w_hs = 0; b_hs = 0;
    u_if.axi_en    = 1'b1;
    u_if.axi_addr  = v.addr;
    u_if.axi_wdata = v.wdata;
    u_if.axi_wsel  = v.wr ? v.wsel : 4'b0000;
    lat = 0;
    got = 1'b0;
    while (!got && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (u_if.reload) got = 1'b1;
    end
    u_if.axi_en = 1'b0;
    chk({p, " reload seen"}, {31'h0, got}, 32'h1);
    chk({p, " latency"}, lat, v.exp_lat);
    chk({p, " resp_err"}, {31'h0, u_if.resp_err}, {31'h0, v.exp_err});
    chk({p, " axi_rdata"}, u_if.axi_rdata, v.exp_rdata);
    @(posedge clk); #1;
    chk({p, " pulse ends"}, {30'h0, u_if.reload, u_if.resp_err}, 32'h0);
    chk({p, " rdata held"}, u_if.axi_rdata, v.exp_rdata);
    @(posedge clk); #1;
    chk({p, " no valid at reload+2"}, {29'h0, u_if.arvalid, u_if.awvalid, u_if.wvalid}, 32'h0);
    if (v.wr) begin
      chk({p, " hs counts"}, ar_hs*10000 + r_hs*1000 + aw_hs*100 + w_hs*10 + b_hs, 111);
      chk({p, " awaddr"}, cap_awaddr, v.addr);
      chk({p, " wdata"}, cap_wdata, v.wdata);
      chk({p, " wstrb/wlast"}, {27'h0, cap_wstrb, cap_wlast}, {27'h0, v.wsel, 1'b1});
      chk({p, " awvalid cycles"}, aw_hi, v.exp_a_cyc);
      chk({p, " wvalid cycles"}, w_hi, v.exp_w_cyc);
    end else begin
      chk({p, " hs counts"}, ar_hs*10000 + r_hs*1000 + aw_hs*100 + w_hs*10 + b_hs, 11000);
      chk({p, " araddr"}, cap_araddr, v.addr);
      chk({p, " arvalid cycles"}, ar_hi, v.exp_a_cyc);
    end
  endtask

  initial begin
    int n;
    //           wr   addr          wdata         wsel     arw rw aww ww bw rdata         resp   lat err exp_rdata     a  w
    vecs[0] = '{1'b0, 32'h1faf_fff0, 32'h0,        4'b0000, 0, 0, 0, 0, 0, 32'h1234_5678, 2'b00, 3, 1'b0, 32'h1234_5678, 1, 0};
    vecs[1] = '{1'b1, 32'h1faf_0010, 32'hdead_beef, 4'b0011, 0, 0, 0, 3, 0, 32'h0,         2'b00, 6, 1'b0, 32'h1234_5678, 1, 4};
    vecs[2] = '{1'b0, 32'h1faf_0020, 32'h0,        4'b0000, 1, 2, 0, 0, 0, 32'hffff_ffff, 2'b10, 6, 1'b1, 32'hffff_ffff, 2, 0};
    vecs[3] = '{1'b1, 32'h1faf_0030, 32'h0102_0304, 4'b1111, 0, 0, 2, 0, 1, 32'h0,         2'b11, 6, 1'b1, 32'hffff_ffff, 3, 1};
    vecs[4] = '{1'b1, 32'h2000_0004, 32'h0bad_f00d, 4'b1000, 0, 0, 0, 0, 0, 32'h0,         2'b00, 3, 1'b0, 32'hffff_ffff, 1, 1};
    vecs[5] = '{1'b0, 32'h0000_0100, 32'h0,        4'b0000, 0, 0, 0, 0, 0, 32'ha5a5_5a5a, 2'b00, 3, 1'b0, 32'ha5a5_5a5a, 1, 0};
    vecs[6] = '{1'b1, 32'h0000_0200, 32'h7777_8888, 4'b0100, 0, 0, 2, 2, 0, 32'h0,         2'b00, 5, 1'b0, 32'ha5a5_5a5a, 3, 3};
    vecs[7] = '{1'b0, 32'h0000_0300, 32'h0,        4'b0000, 0, 3, 0, 0, 0, 32'h0000_0001, 2'b01, 6, 1'b0, 32'h0000_0001, 1, 0};

    cur = vecs[0];
    u_if.axi_en = 1'b0;
    u_if.axi_wsel = 4'b0;
    u_if.axi_addr = 32'h0;
    u_if.axi_wdata = 32'h0;
    resetn = 1'b0;
    #3;
    chk_all_zero("reset");
    repeat (2) @(posedge clk);
    #2 resetn = 1'b1;
    @(posedge clk); #1;

    // back-to-back: each request issued as early as the requester can
    for (int i = 0; i < 8; i++) run(i, vecs[i]);

    // async reset while the bridge waits in R with rready high
    cur = '{1'b0, 32'h0000_0400, 32'h0, 4'b0000, 0, 8, 0, 0, 0, 32'h5555_aaaa, 2'b00, 0, 1'b0, 32'h0, 1, 0};
    u_if.axi_en = 1'b1;
    u_if.axi_addr = cur.addr;
    u_if.axi_wsel = 4'b0000;
    n = 0;
    while (!u_if.rready && n < 20) begin @(posedge clk); #1; n++; end
    u_if.axi_en = 1'b0;
    chk("rst seq rready reached", {31'h0, u_if.rready}, 32'h1);
    #2 resetn = 1'b0;
    #1;
    chk_all_zero("mid-R reset");
    @(negedge clk);
    #2 resetn = 1'b1;
    @(posedge clk); #1;
    run(8, vecs[0]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

endmodule
